button_event_decoder: RTL and testbench
=======================================

# button_event_decoder

Converts one debounced button level into single-cycle, registered event pulses: press, short release, long press, auto-repeat while held, and release. It sits directly downstream of the button debounce stage in the digital lock and feeds the keypad and code-entry logic, so the lock logic never edge-detects or times raw levels. It runs entirely on the 50 MHz system clock and has its own internal tick prescaler.

## Interface

Parameters:
- CLK_DIV, 62500 — clk_in cycles per internal tick (800 Hz tick at 50 MHz); legal range ≥ 2.
- LONG_TICKS, 800 — number of ticks held before the long-press event (1 s); legal range ≥ 1.
- REPEAT_TICKS, 160 — number of ticks between auto-repeat pulses after a long press (200 ms); legal range ≥ 1.

Ports:
- clk_in  input  1  system clock, 50 MHz, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Button_in  input  1  debounced button level, synchronous to clk_in; 1 means pressed.
- press_out  output  1  one-cycle pulse when the button goes down.
- short_out  output  1  one-cycle pulse on release before the long threshold.
- long_out  output  1  one-cycle pulse when the long threshold is reached.
- repeat_out  output  1  one-cycle pulse every REPEAT_TICKS ticks after long_out while still held.
- release_out  output  1  one-cycle pulse on every release.
- held_out  output  1  level; high while the state machine is not IDLE.

## Operation

Prescaler:
- Free-running counter from 0 to CLK_DIV-1, then wraps.
- tick is high for the one cycle where the counter equals CLK_DIV-1.
- It is not restarted on a press, so long-press timing is quantised to one tick period.

Edge detection:
- btn_q is Button_in registered once.
- rise = Button_in & ~btn_q; fall = ~Button_in & btn_q.

States:
- IDLE
  - On rise: press_out ← 1, hold_cnt ← 0, go to PRESSED.
- PRESSED
  - fall has priority: short_out ← 1, release_out ← 1, go to IDLE.
  - Otherwise, on tick with hold_cnt == LONG_TICKS-1: long_out ← 1, rep_cnt ← 0, go to LONG_HELD.
  - Otherwise, on tick: hold_cnt ← hold_cnt + 1.
- LONG_HELD
  - fall has priority: release_out ← 1, go to IDLE. No short_out.
  - Otherwise, on tick with rep_cnt == REPEAT_TICKS-1: repeat_out ← 1, rep_cnt ← 0.
  - Otherwise, on tick: rep_cnt ← rep_cnt + 1.

Counters and arithmetic:
- Counter widths are the minimum bits needed for (parameter − 1); minimum width is 1.
- Counters never wrap in use: they are compared for equality and cleared before overflow.

Boundary conditions:
- A tick on the same edge as rise is not counted. long_out fires on the LONG_TICKS-th tick strictly after the press edge.
- fall on the same edge as the long-threshold tick gives short_out and release_out only; long_out is not asserted.
- fall on the same edge as a repeat tick gives release_out only; repeat_out is not asserted.
- A rise seen in PRESSED or LONG_HELD is impossible while btn_q tracks the input; ignore it.
- Button held through reset: btn_q resets to 0, so press_out fires on the first edge after reset deasserts.

## Timing

- All outputs are registered.
- Latency: when Button_in is first sampled 1 at edge k, press_out is high from edge k to edge k+1. Release uses the same one-cycle latency.
- Every event output is high for exactly one clk_in cycle per event and is never asserted in two consecutive cycles.
- At most one of press_out, short_out, long_out, repeat_out is high in any cycle. release_out coincides only with short_out.
- held_out rises together with press_out and falls together with release_out.
- Reset values: all outputs 0, state IDLE, btn_q 0, prescaler 0, hold_cnt 0, rep_cnt 0.
- Reset asserted mid-hold forces IDLE immediately. No release_out or short_out is produced for the aborted press.

## Test plan

Use CLK_DIV=4, LONG_TICKS=5, REPEAT_TICKS=3 for all scenarios.

1. Reset, then Button_in=1 for 8 cycles, then 0:
   - one press_out, then short_out and release_out in the same cycle one edge after the fall.
   - no long_out; held_out high for exactly 8 cycles.
2. Hold Button_in=1 for 60 cycles:
   - long_out on the 5th tick after the press edge.
   - repeat_out every 12 cycles after that.
   - on release: release_out only, with no short_out.
3. Release aligned to the edge of the 5th tick:
   - short_out and release_out; long_out never asserted.
4. Release aligned to a repeat tick:
   - release_out only; repeat_out count is one fewer than for a hold lasting one cycle longer.
5. Assert reset for 2 cycles during LONG_HELD:
   - all outputs 0 immediately and held_out 0.
   - with Button_in still 1, press_out fires one edge after reset deasserts.
6. Sweep 200 random press/release lengths (1–80 cycles):
   - per press: exactly one press_out and one release_out.
   - pulses mutually exclusive except release_out with short_out.
   - count of short_out plus long_out equals count of press_out.

Source files
------------

// File: rtl/button_event_decoder_if.sv
// Button level in, decoded event pulses out, between the debounce stage and the lock logic.
// The decoder takes the slave side; the upstream/test side takes the master side.
interface button_event_decoder_if;
  logic Button_in;
  logic press_out;
  logic short_out;
  logic long_out;
  logic repeat_out;
  logic release_out;
  logic held_out;

  modport master (
    output Button_in,
    input  press_out,
    input  short_out,
    input  long_out,
    input  repeat_out,
    input  release_out,
    input  held_out
  );

  modport slave (
    input  Button_in,
    output press_out,
    output short_out,
    output long_out,
    output repeat_out,
    output release_out,
    output held_out
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into registered one-cycle press/short/long/repeat/release
// pulses plus a held level, timed by an internal free-running tick prescaler.
module button_event_decoder #(
  parameter int CLK_DIV      = 62500,
  parameter int LONG_TICKS   = 800,
  parameter int REPEAT_TICKS = 160
) (
  input  logic                   clk_in,
  input  logic                   reset,
  button_event_decoder_if.slave  bus
);

  localparam int DIV_W  = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
  localparam int HOLD_W = (LONG_TICKS > 1)   ? $clog2(LONG_TICKS)   : 1;
  localparam int REP_W  = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 32'sd1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(32'sd1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 32'sd1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'sd1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS - 32'sd1);
  localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(32'sd1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } state_t;

  state_t             state_r;
  logic [DIV_W-1:0]   div_cnt_r;
  logic [HOLD_W-1:0]  hold_cnt_r;
  logic [REP_W-1:0]   rep_cnt_r;
  logic               btn_q_r;
  logic               press_r;
  logic               short_r;
  logic               long_r;
  logic               repeat_r;
  logic               release_r;
  logic               held_r;
  logic               tick_s;
  logic               rise_s;
  logic               fall_s;

  // Tick strobe and edge detect from the registered copy of the button level.
  always_comb begin
    tick_s = (div_cnt_r == DIV_LAST);
    rise_s = bus.Button_in & ~btn_q_r;
    fall_s = ~bus.Button_in & btn_q_r;
  end

  // Free-running prescaler (never restarted by a press) and button level register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_cnt_r <= '0;
      btn_q_r   <= 1'b0;
    end else begin
      div_cnt_r <= tick_s ? '0 : (div_cnt_r + DIV_ONE);
      btn_q_r   <= bus.Button_in;
    end
  end

  // Event state machine; every pulse defaults low so each lasts exactly one cycle.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= '0;
      rep_cnt_r  <= '0;
      press_r    <= 1'b0;
      short_r    <= 1'b0;
      long_r     <= 1'b0;
      repeat_r   <= 1'b0;
      release_r  <= 1'b0;
      held_r     <= 1'b0;
    end else begin
      press_r   <= 1'b0;
      short_r   <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
      release_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A tick coinciding with the press edge is deliberately not counted.
          if (rise_s) begin
            press_r    <= 1'b1;
            held_r     <= 1'b1;
            hold_cnt_r <= '0;
            state_r    <= ST_PRESSED;
          end else begin
            held_r     <= 1'b0;
          end
        end
        ST_PRESSED: begin
          if (fall_s) begin
            short_r   <= 1'b1;
            release_r <= 1'b1;
            held_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end else if (tick_s) begin
            if (hold_cnt_r == HOLD_LAST) begin
              long_r    <= 1'b1;
              rep_cnt_r <= '0;
              state_r   <= ST_LONG_HELD;
            end else begin
              hold_cnt_r <= hold_cnt_r + HOLD_ONE;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        ST_LONG_HELD: begin
          if (fall_s) begin
            release_r <= 1'b1;
            held_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end else if (tick_s) begin
            if (rep_cnt_r == REP_LAST) begin
              repeat_r  <= 1'b1;
              rep_cnt_r <= '0;
            end else begin
              rep_cnt_r <= rep_cnt_r + REP_ONE;
            end
          end else begin
            rep_cnt_r <= rep_cnt_r;
          end
        end
        default: begin
          held_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.press_out   = press_r;
  assign bus.short_out   = short_r;
  assign bus.long_out    = long_r;
  assign bus.repeat_out  = repeat_r;
  assign bus.release_out = release_r;
  assign bus.held_out    = held_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench: each press is planned arithmetically into timed events, and a monitor
// compares the DUT's pulses and held level against that queue cycle by cycle.
module tb_button_event_decoder;
  localparam int CLK_DIV      = 4;
  localparam int LONG_TICKS   = 5;
  localparam int REPEAT_TICKS = 3;

  typedef struct {
    int         ev_edge;
    logic [4:0] mask;  // {press, short, long, repeat, release}
  } ev_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  button_event_decoder_if bus ();

  button_event_decoder #(
    .CLK_DIV(CLK_DIV), .LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_cnt = 0;
  int   n_press = 0, n_short = 0, n_long = 0, n_repeat = 0, n_release = 0;
  logic held_model = 1'b0;
  int   mon_e;
  logic [4:0] act_m, exp_m;

  // Index of the next rising edge, counted from the first edge after reset release.
  always @(posedge clk_in) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  function automatic int first_tick_after(int n0);
    int e;
    e = n0 + 1;
    while ((e % CLK_DIV) != (CLK_DIV - 1)) e++;
    return e;
  endfunction

  function automatic int long_edge_of(int n0);
    return first_tick_after(n0) + (LONG_TICKS - 1) * CLK_DIV;
  endfunction

  task automatic push_ev(int e, logic [4:0] m);
    ev_t ev;
    ev.ev_edge = e;
    ev.mask    = m;
    exp_q.push_back(ev);
  endtask

  // Press first sampled at edge n0, release first sampled at edge n0+len.
  task automatic plan_press(input int n0, input int len, output int reps);
    int r, le;
    r    = n0 + len;
    le   = long_edge_of(n0);
    reps = 0;
    push_ev(n0, 5'b10000);
    if (le < r) begin
      push_ev(le, 5'b00100);
      for (int e = le + REPEAT_TICKS * CLK_DIV; e < r; e += REPEAT_TICKS * CLK_DIV) begin
        push_ev(e, 5'b00010);
        reps++;
      end
      push_ev(r, 5'b00001);
    end else begin
      push_ev(r, 5'b01001);
    end
  endtask

  task automatic wait_cyc(int n);
    repeat (n) begin
      @(negedge clk_in);
      #1;
    end
  endtask

  task automatic run_press(int len, int gap);
    int reps, snap;
    plan_press(edge_cnt, len, reps);
    snap = n_repeat;
    bus.Button_in = 1'b1;
    wait_cyc(len);
    bus.Button_in = 1'b0;
    wait_cyc(gap);
    total++;
    if ((n_repeat - snap) !== reps) begin
      bad++;
      $display("FAIL repeat_count len=%0d actual=%0d required=%0d", len, n_repeat - snap, reps);
    end
  endtask

  task automatic check_outputs_zero(string name);
    logic [5:0] o;
    o = {bus.press_out, bus.short_out, bus.long_out, bus.repeat_out, bus.release_out, bus.held_out};
    total++;
    if (o !== 6'b000000) begin
      bad++;
      $display("FAIL %s actual=%b required=000000", name, o);
    end
  endtask

  // Monitor: pop expected events due at the edge just past and compare with the DUT.
  initial begin
    forever begin
      @(negedge clk_in);
      if (reset) begin
        held_model = 1'b0;
      end else begin
        mon_e = edge_cnt - 1;
        act_m = {bus.press_out, bus.short_out, bus.long_out, bus.repeat_out, bus.release_out};
        exp_m = 5'b00000;
        while (exp_q.size() > 0 && exp_q[0].ev_edge <= mon_e) begin
          if (exp_q[0].ev_edge < mon_e) begin
            total++;
            bad++;
            $display("FAIL stale_event edge=%0d actual=missed required=%b", exp_q[0].ev_edge, exp_q[0].mask);
          end else begin
            exp_m = exp_m | exp_q[0].mask;
          end
          void'(exp_q.pop_front());
        end
        if (act_m != 5'b00000 || exp_m != 5'b00000) begin
          total++;
          if (act_m !== exp_m) begin
            bad++;
            $display("FAIL event_mask edge=%0d actual=%b required=%b", mon_e, act_m, exp_m);
          end
        end
        if (exp_m[4]) held_model = 1'b1;
        if (exp_m[0]) held_model = 1'b0;
        total++;
        if (bus.held_out !== held_model) begin
          bad++;
          $display("FAIL held_level edge=%0d actual=%b required=%b", mon_e, bus.held_out, held_model);
        end
        n_press   += int'(act_m[4]);
        n_short   += int'(act_m[3]);
        n_long    += int'(act_m[2]);
        n_repeat  += int'(act_m[1]);
        n_release += int'(act_m[0]);
      end
    end
  end

  initial begin
    int n0, len, reps, sp, sr, ssl;
    bus.Button_in = 1'b0;
    reset = 1'b1;
    wait_cyc(3);
    check_outputs_zero("reset_state");
    reset = 1'b0;
    wait_cyc(2);

    // Short press, then long hold with repeats.
    run_press(8, 6);
    run_press(60, 6);

    // Release on the long-threshold tick: short, never long.
    n0 = edge_cnt;
    run_press(long_edge_of(n0) - n0, 5);

    // Release on a repeat tick, then one cycle later.
    n0 = edge_cnt;
    run_press(long_edge_of(n0) + REPEAT_TICKS * CLK_DIV - n0, 5);
    n0 = edge_cnt;
    run_press(long_edge_of(n0) + REPEAT_TICKS * CLK_DIV - n0 + 1, 5);

    // Reset during LONG_HELD with the button still down.
    plan_press(edge_cnt, 1000, reps);
    bus.Button_in = 1'b1;
    wait_cyc(40);
    reset = 1'b1;
    #1;
    check_outputs_zero("reset_mid_hold");
    exp_q.delete();
    wait_cyc(2);
    reset = 1'b0;
    run_press(10, 5);

    // Random sweep.
    sp  = n_press;
    sr  = n_release;
    ssl = n_short + n_long;
    for (int i = 0; i < 200; i++) begin
      len = int'($urandom_range(80, 1));
      run_press(len, int'($urandom_range(12, 1)));
    end
    total++;
    if ((n_press - sp) !== 200) begin
      bad++;
      $display("FAIL sweep_press_count actual=%0d required=200", n_press - sp);
    end
    total++;
    if ((n_release - sr) !== 200) begin
      bad++;
      $display("FAIL sweep_release_count actual=%0d required=200", n_release - sr);
    end
    total++;
    if ((n_short + n_long - ssl) !== 200) begin
      bad++;
      $display("FAIL sweep_short_plus_long actual=%0d required=200", n_short + n_long - ssl);
    end

    wait_cyc(4);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drained actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
